decode_issue_ctrl: RTL

//   Decode-stage issue controller between IMEM fetch and execute in the RV32I core.
//   - Buffers fetched {pc, inst} in a small FIFO.
//   - Drives the stage-1 immediate generator from the FIFO head.
//   - Issues {pc, inst, imm} to execute with a valid/ready handshake.
//   - Flushes on redirect; optionally inserts a load-use bubble.

---
 rtl/decode_issue_ctrl_pkg.sv | 50 +++++
 rtl/decode_issue_ctrl_fifo.sv | 62 ++++++
 rtl/decode_issue_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared opcodes, NOP encoding, FSM states and immediate decode for decode_issue_ctrl.
package decode_issue_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_SHADOW = 1'b1
    } state_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] inst);
        logic [31:0] imm;
        imm = '0;
        case (inst[6:0])
            OPC_LOAD, OPC_JALR: imm = {{20{inst[31]}}, inst[31:20]};
            OPC_OP_IMM: begin
                // funct3 001/101 are the shifts: shamt is unsigned
                if (inst[13:12] == 2'b01)
                    imm = {27'd0, inst[24:20]};
                else
                    imm = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE:         imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'h000};
            OPC_JAL:           imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:           imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic uses_rs1(input logic [31:0] inst);
        return !(inst[6:0] == OPC_LUI || inst[6:0] == OPC_AUIPC || inst[6:0] == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] inst);
        return (inst[6:0] == OPC_OP || inst[6:0] == OPC_STORE || inst[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_fifo.sv
// decode_issue_fifo: {pc, inst} storage with wrapping pointers and occupancy count.
module decode_issue_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [31:0]                  wr_pc,
    input  logic [31:0]                  wr_inst,
    output logic [31:0]                  head_pc,
    output logic [31:0]                  head_inst,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= wr_pc;
            inst_mem[wr_ptr] <= wr_inst;
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: fetch buffer, immediate decode, issue handshake, flush.
// Optional load-use interlock built when LOAD_USE_INTERLOCK_EN is defined.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        if_valid,
    output logic                        if_ready,
    input  logic [31:0]                 if_pc,
    input  logic [31:0]                 if_inst,
    input  logic                        flush,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic [31:0]                 id_pc,
    output logic [31:0]                 id_inst,
    output logic [31:0]                 id_imm,
    output logic                        id_bubble,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        stall;
    logic [31:0] head_pc;
    logic [31:0] head_inst;

    decode_issue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .wr_pc     (if_pc),
        .wr_inst   (if_inst),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign if_ready = !full;
    assign push     = if_valid & if_ready & !flush;
    assign id_valid = !empty & !flush & !stall;
    assign pop      = id_valid & id_ready;

    assign id_pc   = id_valid ? head_pc : '0;
    assign id_inst = id_valid ? head_inst : NOP;
    assign id_imm  = id_valid ? imm_gen(head_inst) : '0;

`ifdef LOAD_USE_INTERLOCK_EN
    state_t     state;
    state_t     state_nxt;
    logic [4:0] ld_rd;
    logic [4:0] ld_rd_nxt;
    logic       load_pop;

    assign load_pop = pop && (head_inst[6:0] == OPC_LOAD) && (head_inst[11:7] != 5'd0);

    always_comb begin
        stall = 1'b0;
        if (state == S_SHADOW && !empty)
            stall = (uses_rs1(head_inst) && head_inst[19:15] == ld_rd) ||
                    (uses_rs2(head_inst) && head_inst[24:20] == ld_rd);
    end

    assign id_bubble = stall & id_ready & !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            ld_rd <= '0;
        end else begin
            state <= state_nxt;
            ld_rd <= ld_rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_rd_nxt = ld_rd;
        if (flush) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (load_pop) begin
                        state_nxt = S_SHADOW;
                        ld_rd_nxt = head_inst[11:7];
                    end
                end
                S_SHADOW: begin
                    // a stalled head cannot pop, so load_pop already excludes it
                    if (id_ready) begin
                        if (load_pop) begin
                            state_nxt = S_SHADOW;
                            ld_rd_nxt = head_inst[11:7];
                        end else begin
                            state_nxt = S_RUN;
                        end
                    end
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end
`else
    assign stall     = 1'b0;
    assign id_bubble = 1'b0;
`endif

endmodule
